// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 driver: register offsets, FSM encoding, timing defaults.
package ws2812_pkg;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DATA   = 2'd2;
  localparam logic [1:0] ADR_TIMING = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  localparam int DEF_T0H  = 16;
  localparam int DEF_T1H  = 32;
  localparam int DEF_TBIT = 50;
  localparam int DEF_TRST = 200;

  typedef struct packed {
    logic [7:0] trst;
    logic [7:0] tbit;
    logic [7:0] t1h;
    logic [7:0] t0h;
  } timing_t;

  function automatic logic [7:0] min1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [7:0] hi_time(input timing_t t, input logic b);
    return min1(b ? t.t1h : t.t0h);
  endfunction

endpackage

// File: rtl/ws2812_fifo.sv
// Synchronous 24-bit pixel FIFO; registered pointers, combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module ws2812_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] dat_o,
  output logic [4:0]       level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [4:0]       cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == 5'(DEPTH));
  assign empty_o = (cnt_q == 5'd0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dat_o   = mem_q[rd_ptr_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + {4'd0, do_push} - {4'd0, do_pop};
    end
  end

endmodule

// File: rtl/ws2812_driver.sv
// Wishbone-controlled WS2812 serialiser: pixels queue in a FIFO and stream MSB first, then a latch gap.
// Single-cycle registered ack; DATA writes into a full FIFO are dropped and flagged as OVF.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int T0H_DEF    = DEF_T0H,
  parameter int T1H_DEF    = DEF_T1H,
  parameter int TBIT_DEF   = DEF_TBIT,
  parameter int TRST_DEF   = DEF_TRST
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        led_o,
  output logic        irq_o
);

  logic        ack_q;
  logic [31:0] dat_q;
  logic        en_q, ovf_q;
  timing_t     tim_q;

  logic [2:0]  state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  cnt_q, cnt_d, hi_q, hi_d, tbit_q, tbit_d;
  logic [11:0] lat_q, lat_d;

  logic        req, wr, rd;
  logic        wr_ctrl, wr_status, wr_data, wr_timing;
  logic        f_push, f_pop, f_flush, f_full, f_empty;
  logic [23:0] f_dat;
  logic [4:0]  f_level;
  logic [31:0] rdata;
  logic        busy, cont, short_low, per_done, near_done;
  logic [8:0]  cnt_nx;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr        = req & wbs_we_i;
  assign rd        = req & ~wbs_we_i;
  assign wr_ctrl   = wr && (wbs_adr_i[3:2] == ADR_CTRL);
  assign wr_status = wr && (wbs_adr_i[3:2] == ADR_STATUS);
  assign wr_data   = wr && (wbs_adr_i[3:2] == ADR_DATA);
  assign wr_timing = wr && (wbs_adr_i[3:2] == ADR_TIMING);

  assign f_push  = wr_data;
  assign f_pop   = (state_q == S_LOAD);
  assign f_flush = wr_ctrl & wbs_dat_i[1];

  ws2812_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (f_push),
    .dat_i   (wbs_dat_i[23:0]),
    .pop_i   (f_pop),
    .flush_i (f_flush),
    .dat_o   (f_dat),
    .level_o (f_level),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign busy = (state_q != S_IDLE);

  always_comb begin
    rdata = 32'd0;
    case (wbs_adr_i[3:2])
      ADR_CTRL:   rdata = {31'd0, en_q};
      ADR_STATUS: rdata = {23'd0, ovf_q, f_empty, f_full, busy, f_level};
      ADR_TIMING: rdata = tim_q;
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
      tim_q <= '{trst: 8'(TRST_DEF), tbit: 8'(TBIT_DEF), t1h: 8'(T1H_DEF), t0h: 8'(T0H_DEF)};
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdata : 32'd0;
      if (wr_ctrl) en_q <= wbs_dat_i[0];
      if (wr_data && f_full && !f_pop) ovf_q <= 1'b1;
      else if (wr_status && wbs_dat_i[8]) ovf_q <= 1'b0;
      if (wr_timing) tim_q <= wbs_dat_i;
    end
  end

  // cnt_q counts clocks of the current bit period, starting at 1 on its first HIGH clock.
  // When TBIT does not exceed the high time, LOW is a single clock regardless of the count.
  assign cont      = en_q & ~f_empty;
  assign cnt_nx    = {1'b0, cnt_q} + 9'd1;
  assign short_low = (tbit_q <= hi_q);
  assign per_done  = (cnt_q >= tbit_q) | short_low;
  assign near_done = (cnt_nx >= {1'b0, tbit_q}) | short_low;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    tbit_d  = tbit_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (cont) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = f_dat;
        bit_d   = 5'd23;
        cnt_d   = 8'd1;
        hi_d    = hi_time(tim_q, f_dat[23]);
        tbit_d  = tim_q.tbit;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == hi_q) state_d = S_LOW;
      end
      S_LOW: begin
        cnt_d = cnt_q + 8'd1;
        if (bit_q != 5'd0) begin
          if (per_done) begin
            shift_d = shift_q << 1;
            bit_d   = bit_q - 5'd1;
            cnt_d   = 8'd1;
            hi_d    = hi_time(tim_q, shift_q[22]);
            tbit_d  = tim_q.tbit;
            state_d = S_HIGH;
          end
        // LOAD takes the last low clock of bit 0 so back-to-back pixels have no gap.
        end else if (cont && near_done) begin
          state_d = S_LOAD;
        end else if (per_done) begin
          lat_d   = {min1(tim_q.trst), 4'd0} - 12'd1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        lat_d = lat_q - 12'd1;
        if (lat_q == 12'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= 8'd1;
      tbit_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      tbit_q  <= tbit_d;
      lat_q   <= lat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign led_o     = (state_q == S_HIGH);
  assign irq_o     = (state_q == S_LATCH) && (lat_q == 12'd0);

endmodule

// File: tb/tb_ws2812_driver.sv
// Directed + randomized bench: the LED waveform is measured as pulses and compared with per-bit timing derived from the pixel list.
module tb_ws2812_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dwr, drd;
  logic        ack, led, irq;

  always #5 clk = ~clk;

  ws2812_driver #(.FIFO_DEPTH(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dwr),
    .wbs_dat_o (drd),
    .wbs_ack_o (ack),
    .led_o     (led),
    .irq_o     (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Waveform monitor: rise times, high-pulse lengths, irq times (in sampled cycles).
  int   cyc_n = 0;
  int   rise_t[$];
  int   hi_len[$];
  int   irq_t[$];
  int   hi_run = 0;
  logic led_prev = 1'b0;

  always @(negedge clk) begin
    cyc_n++;
    if (led === 1'b1 && led_prev !== 1'b1) rise_t.push_back(cyc_n);
    if (led !== 1'b1 && led_prev === 1'b1) hi_len.push_back(hi_run);
    hi_run   = (led === 1'b1) ? hi_run + 1 : 0;
    if (irq === 1'b1) irq_t.push_back(cyc_n);
    led_prev = led;
  end

  logic [23:0] exp_px[$];
  int          m_t0h, m_t1h, m_tbit, m_trst;
  logic [23:0] px, p0;
  int          t0, t1, tb, tr, mx, np, k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dwr = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack !== 1'b1 && n < 8);
    r = drd;
    check("wb_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'd0, r);
    check(tag, r, e);
  endtask

  task automatic set_timing(input int a0, input int a1, input int ab, input int ar);
    m_t0h = a0; m_t1h = a1; m_tbit = ab; m_trst = ar;
    wr(32'hC, {ar[7:0], ab[7:0], a1[7:0], a0[7:0]});
  endtask

  task automatic clr_mon();
    rise_t.delete();
    hi_len.delete();
    irq_t.delete();
  endtask

  task automatic push_rand(input int n, input int keep);
    logic [23:0] v;
    for (int i = 0; i < n; i++) begin
      v = 24'($urandom);
      wr(32'h8, {8'd0, v});
      if (i < keep) exp_px.push_back(v);
    end
  endtask

  // Expected bit i: high = T1H or T0H (0 counts as 1); period = max(TBIT, high+1).
  task automatic check_frame(input string tag, input int settle);
    int hs[$];
    int ps[$];
    int h, p, n, w, f0, lat;
    int budget = 0;
    foreach (exp_px[i]) begin
      for (int b = 23; b >= 0; b--) begin
        h = exp_px[i][b] ? m_t1h : m_t0h;
        if (h == 0) h = 1;
        p = (m_tbit > h) ? m_tbit : h + 1;
        hs.push_back(h);
        ps.push_back(p);
        budget += p;
      end
    end
    lat = 16 * ((m_trst == 0) ? 1 : m_trst);
    budget += lat + 200;
    w = 0;
    while (irq_t.size() == 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    repeat (settle) @(negedge clk);
    n = hs.size();
    check({tag, "_irqs"}, irq_t.size(), 1);
    check({tag, "_bits"}, rise_t.size(), n);
    check({tag, "_pulses"}, hi_len.size(), n);
    if (rise_t.size() == n && hi_len.size() == n && irq_t.size() >= 1 && n > 0) begin
      f0 = n_fail;
      for (int i = 0; i < n && n_fail == f0; i++) begin
        check($sformatf("%s_high%0d", tag, i), hi_len[i], hs[i]);
        if (i < n - 1) check($sformatf("%s_period%0d", tag, i), rise_t[i+1] - rise_t[i], ps[i]);
      end
      check({tag, "_latch"}, irq_t[0] - rise_t[n-1], ps[n-1] + lat - 1);
    end
  endtask

  initial begin
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; dwr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", {31'd0, led}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", drd, 32'd0);
    @(negedge clk) rst = 1'b0;
    rd_chk("rst_status", 32'h4, 32'h80);
    rd_chk("rst_timing", 32'hC, 32'hC8322010);
    rd_chk("rst_ctrl",   32'h0, 32'h0);

    // Single pixel 0x800000 with default timing.
    m_t0h = 16; m_t1h = 32; m_tbit = 50; m_trst = 200;
    clr_mon();
    exp_px = {24'h800000};
    wr(32'h0, 32'h1);
    wr(32'h8, 32'h800000);
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    repeat (5) @(posedge clk);
    rd_chk("busy_status", 32'h4, 32'hA0);
    check_frame("single", 20);
    rd_chk("idle_status", 32'h4, 32'h80);

    // Overflow: 9 pushes into 8 entries; the 9th must be dropped.
    wr(32'h0, 32'h0);
    set_timing(2, 5, 8, 1);
    exp_px.delete();
    push_rand(9, 8);
    rd_chk("ovf_status", 32'h4, 32'h148);
    wr(32'h4, 32'h100);
    rd_chk("ovf_clear", 32'h4, 32'h048);
    clr_mon();
    wr(32'h0, 32'h1);
    check_frame("drain8", 20);
    rd_chk("drain_status", 32'h4, 32'h80);

    // Three pixels pushed back-to-back with EN already set.
    clr_mon();
    exp_px.delete();
    push_rand(3, 3);
    check_frame("b2b3", 40);

    // Randomized timing and pixel counts.
    for (int it = 0; it < 4; it++) begin
      t0 = $urandom_range(1, 6);
      t1 = $urandom_range(1, 8);
      mx = (t0 > t1) ? t0 : t1;
      tb = $urandom_range(mx + 2, mx + 8);
      tr = $urandom_range(0, 2);
      np = $urandom_range(1, 3);
      wr(32'h0, 32'h0);
      set_timing(t0, t1, tb, tr);
      clr_mon();
      exp_px.delete();
      push_rand(np, np);
      wr(32'h0, 32'h1);
      check_frame($sformatf("rand%0d", it), 20);
    end

    // T0H=0 treated as 1, TRST=2 gives 32-clock latch.
    wr(32'h0, 32'h0);
    m_t0h = 0; m_t1h = 4; m_tbit = 16; m_trst = 2;
    wr(32'hC, 32'h02100400);
    clr_mon();
    exp_px.delete();
    push_rand(1, 1);
    wr(32'h0, 32'h1);
    check_frame("t0h_zero", 20);

    // TBIT below the high time: LOW shrinks to one clock; TRST=0 gives 16 clocks.
    wr(32'h0, 32'h0);
    set_timing(3, 6, 4, 0);
    clr_mon();
    exp_px.delete();
    push_rand(1, 1);
    wr(32'h0, 32'h1);
    check_frame("short_low", 20);

    // FLUSH during pixel 1 of 4.
    wr(32'h0, 32'h0);
    set_timing(2, 5, 8, 1);
    clr_mon();
    exp_px.delete();
    push_rand(4, 1);
    wr(32'h0, 32'h1);
    k = 0;
    while (rise_t.size() == 0 && k < 100) begin @(negedge clk); k++; end
    wr(32'h0, 32'h3);
    rd_chk("flush_ctrl",   32'h0, 32'h1);
    rd_chk("flush_status", 32'h4, 32'hA0);
    check_frame("flush", 300);
    rd_chk("flush_idle", 32'h4, 32'h80);

    // EN cleared mid-pixel: current pixel completes, the second stays queued.
    wr(32'h0, 32'h0);
    clr_mon();
    exp_px.delete();
    push_rand(2, 1);
    wr(32'h0, 32'h1);
    k = 0;
    while (rise_t.size() == 0 && k < 100) begin @(negedge clk); k++; end
    wr(32'h0, 32'h0);
    check_frame("en_clear", 300);
    rd_chk("en_clear_status", 32'h4, 32'h01);
    wr(32'h0, 32'h2);
    rd_chk("flush_only_status", 32'h4, 32'h80);

    // Reset asserted while bit 10 of an all-ones pixel is high.
    set_timing(4, 9, 12, 1);
    clr_mon();
    p0 = 24'hFFFFFF;
    wr(32'h8, {8'd0, p0});
    px = 24'($urandom);
    wr(32'h8, {8'd0, px});
    wr(32'h0, 32'h1);
    k = 0;
    while (!(rise_t.size() >= 11 && led === 1'b1) && k < 3000) begin @(negedge clk); k++; end
    check("rst_mid_reached", {31'd0, led}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_led", {31'd0, led}, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_dat", drd, 32'd0);
    rst = 1'b0;
    rd_chk("rst_mid_status", 32'h4, 32'h80);
    rd_chk("rst_mid_timing", 32'hC, 32'hC8322010);
    rd_chk("rst_mid_ctrl",   32'h0, 32'h0);
    repeat (50) @(negedge clk);
    check("rst_mid_quiet", {31'd0, led}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_driver.md
WS2812_DRIVER -- requirements
Module: ws2812_driver

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 8, meaning pixel FIFO depth; power of two, 2..16.
REQ-002 The module SHALL have parameter T0H_DEF, default 16, meaning reset value of T0H, in clocks.
REQ-003 The module SHALL have parameter T1H_DEF, default 32, meaning reset value of T1H, in clocks.
REQ-004 The module SHALL have parameter TBIT_DEF, default 50, meaning reset value of TBIT, in clocks.
REQ-005 The module SHALL have parameter TRST_DEF, default 200, meaning reset value of TRST, in units of 16 clocks.
REQ-006 The module SHALL have these ports:
- wb_clk_i  in  1  the single clock; one clock, every flop on its rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_adr_i  in  32  address; only [3:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- led_o  out  1  WS2812 serial data line.
- irq_o  out  1  one-cycle pulse on frame-latch completion.

Function
REQ-007 Register map SHALL be:
- 0x0 CTRL rw: [0] EN; [1] FLUSH, self-clearing, reads 0.
- 0x4 STATUS: [4:0] LEVEL ro; [5] BUSY ro; [6] FULL ro; [7] EMPTY ro; [8] OVF sticky, write-1-clear.
- 0x8 DATA wo: [23:0] GRB pixel pushed into FIFO; reads 0.
- 0xC TIMING rw: [7:0] T0H, [15:8] T1H, [23:16] TBIT, [31:24] TRST.
REQ-008 Ack SHALL be registered: wbs_ack_o = 1 for exactly one cycle, the cycle after cyc&stb&~ack; one access per ack.
REQ-009 Read data SHALL be registered with the ack; reads have no side effects.
REQ-010 A DATA write with the FIFO full SHALL be dropped and SHALL set OVF; FIFO contents SHALL be unchanged.
REQ-011 FLUSH SHALL empty the FIFO in the cycle the write completes; a serialisation in progress SHALL finish its current pixel.
REQ-012 The FSM SHALL have states IDLE, LOAD, HIGH, LOW and LATCH.
- IDLE: EN=1 and FIFO non-empty -> LOAD.
- LOAD: one cycle; pops one pixel into a 24-bit shift register; bit index = 23 -> HIGH.
- HIGH: led_o=1 for T1H clocks if current bit = 1, else T0H clocks -> LOW.
- LOW: led_o=0 until the bit period totals TBIT clocks.
- LOW end: next bit -> HIGH; after bit 0, FIFO non-empty and EN=1 -> LOAD; otherwise -> LATCH.
- LATCH: led_o=0 for TRST*16 clocks -> IDLE, pulsing irq_o in the exit cycle.
REQ-013 Bits SHALL be sent MSB first (G[7] first); there SHALL be no gap between consecutive pixels when the FIFO stays non-empty.
REQ-014 A bit-period counter SHALL be 8 bits; if TBIT <= high time, LOW SHALL last exactly 1 clock.
REQ-015 T0H=0 or T1H=0 SHALL be treated as 1.
REQ-016 TRST=0 SHALL give a 16-clock latch.
REQ-017 EN cleared mid-pixel SHALL let the current pixel complete, then -> LATCH.
REQ-018 TIMING writes SHALL take effect at the next bit start.
REQ-019 BUSY SHALL be 1 in every state except IDLE.
REQ-020 A push and a pop in the same cycle SHALL leave LEVEL unchanged; a push when FULL with a simultaneous pop SHALL be accepted.

Reset
REQ-021 While wb_rst_i is high, outputs SHALL be: led_o=0, irq_o=0, wbs_ack_o=0, wbs_dat_o=0.
REQ-022 While wb_rst_i is high, state SHALL be: FSM=IDLE, FIFO empty, EN=0, OVF=0, TIMING={TRST_DEF,TBIT_DEF,T1H_DEF,T0H_DEF}.
REQ-023 Reset asserted mid-pixel SHALL drop led_o to 0 immediately, with no partial-bit completion.

Structure
REQ-024 Package ws2812_pkg SHALL hold register offsets, FSM state encoding, and the timing defaults.
REQ-025 Sub-module ws2812_fifo SHALL be a synchronous FIFO, 24 bits by FIFO_DEPTH, with level, full and empty outputs.

Verification
REQ-026 EN=1, push 0x800000 -> 24 bits on led_o: first high 32 clocks, remaining 23 highs 16 clocks each, every period 50; then 3200 low clocks; irq_o one pulse.
REQ-027 Push 9 pixels with EN=0 and FIFO_DEPTH=8 -> LEVEL=8, FULL=1, OVF=1; write 0x100 to STATUS -> OVF=0.
REQ-028 EN=1, push 3 pixels back-to-back -> 72 contiguous bit periods, a single LATCH, a single irq_o.
REQ-029 TIMING=0x02100400 -> T0H=0 treated as 1 clock high, T1H=4, TBIT=16, latch 32 clocks.
REQ-030 Assert wb_rst_i at bit 10 of a pixel -> led_o=0 the same cycle, LEVEL=0, TIMING back to defaults.
REQ-031 FLUSH during pixel 1 of 4 -> pixel 1 completes, LATCH, LEVEL=0, no further bits.
